// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program/data loader.
//   - beat target encodings carried on in_sel
//   - loader FSM state encoding
//   - address/counter widths and the byte-to-word index helper
package loader_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WIDX_W = ADDR_W - 2;   // word index width of a byte address
    localparam int CNT_W  = 16;           // load_count width
    localparam int DLY_W  = 4;            // settle counter width (START_DELAY <= 15)

    typedef enum logic [1:0] {
        SEL_IMEM  = 2'b00,
        SEL_DMEM  = 2'b01,
        SEL_ENTRY = 2'b10,
        SEL_RSVD  = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10,
        ST_ERROR  = 2'b11
    } state_e;

    function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/loader_addr_chk.sv
// loader_addr_chk: combinational legality check for one load beat.
// Ports:
//   sel        in  2  : beat target (imem / dmem / entry / reserved)
//   addr       in  32 : byte address of the target word
//   data_lsb   in  2  : low bits of the beat data (entry alignment)
//   last       in  1  : beat is the final one of the load
//   legal      out 1  : beat may be committed
//   is_last_ok out 1  : beat is legal and closes the load
module loader_addr_chk
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        data_lsb,
    input  logic              last,
    output logic              legal,
    output logic              is_last_ok
);

    logic              aligned;
    logic [WIDX_W-1:0] idx;

    always_comb begin
        aligned = (addr[1:0] == 2'b00);
        idx     = word_idx(addr);
        legal   = 1'b0;
        case (sel_e'(sel))
            SEL_IMEM:  legal = aligned && (idx < WIDX_W'(IMEM_WORDS));
            SEL_DMEM:  legal = aligned && (idx < WIDX_W'(DMEM_WORDS));
            SEL_ENTRY: legal = (data_lsb == 2'b00);
            default:   legal = 1'b0;
        endcase
        // An illegal last beat must not close the load: error wins.
        is_last_ok = legal && last;
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams load beats into instruction/data memory write ports,
// captures the core entry address, then releases the core via tbStart.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready          : beat handshake (ready only while loading)
//   in_sel/in_addr/in_data     : beat target, byte address, data/entry value
//   in_last                    : final beat of the load
//   imem_we/addr/wdata         : registered instruction memory write port
//   dmem_we/addr/wdata         : registered data memory write port
//   tbStart, initInstAddr      : core run enable (sticky) and reset PC
//   err                        : sticky load error
//   load_count                 : committed memory beats, saturating
module mem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS  = 64,
    parameter int DMEM_WORDS  = 64,
    parameter int START_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              tbStart,
    output logic [ADDR_W-1:0] initInstAddr,
    output logic              err,
    output logic [CNT_W-1:0]  load_count
);

    state_e            state_q, state_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              tb_start_q, tb_start_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  load_count_q, load_count_d;
    logic [DLY_W-1:0]  dly_q, dly_d;

    logic legal;
    logic is_last_ok;
    logic accept;

    loader_addr_chk #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS)
    ) u_chk (
        .sel        (in_sel),
        .addr       (in_addr),
        .data_lsb   (in_data[1:0]),
        .last       (in_last),
        .legal      (legal),
        .is_last_ok (is_last_ok)
    );

    assign accept = in_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;   // strobes are single-cycle unless re-armed
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        tb_start_d   = tb_start_q;
        init_addr_d  = init_addr_q;
        err_d        = err_q;
        load_count_d = load_count_q;
        dly_d        = dly_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        case (sel_e'(in_sel))
                            SEL_IMEM: begin
                                imem_we_d    = 1'b1;
                                imem_addr_d  = in_addr;
                                imem_wdata_d = in_data;
                            end
                            SEL_DMEM: begin
                                dmem_we_d    = 1'b1;
                                dmem_addr_d  = in_addr;
                                dmem_wdata_d = in_data;
                            end
                            SEL_ENTRY: init_addr_d = in_data;
                            default: ;
                        endcase
                        if ((in_sel == SEL_IMEM || in_sel == SEL_DMEM)
                            && load_count_q != {CNT_W{1'b1}}) begin
                            load_count_d = load_count_q + 1'b1;
                        end
                        if (is_last_ok) begin
                            state_d = ST_SETTLE;
                            dly_d   = DLY_W'(START_DELAY);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                // Entered with START_DELAY loaded; run asserts one edge
                // after the count reaches zero.
                if (dly_q == '0) begin
                    state_d    = ST_RUN;
                    tb_start_d = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            default: ;  // RUN and ERROR hold until reset
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            tb_start_q   <= 1'b0;
            init_addr_q  <= '0;
            err_q        <= 1'b0;
            load_count_q <= '0;
            dly_q        <= '0;
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            tb_start_q   <= tb_start_d;
            init_addr_q  <= init_addr_d;
            err_q        <= err_d;
            load_count_q <= load_count_d;
            dly_q        <= dly_d;
        end
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign tbStart      = tb_start_q;
    assign initInstAddr = init_addr_q;
    assign err          = err_q;
    assign load_count   = load_count_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed bench for mem_loader. Expected memory writes are
// queued when a beat is driven and popped by a write-port monitor.
module tb_mem_loader;
    import loader_pkg::*;

    localparam int IW  = 64;
    localparam int DW  = 64;
    localparam int DLY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'b00;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        imem_we, dmem_we, tbStart, err;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, initInstAddr;
    logic [15:0] load_count;

    always #5 clk = ~clk;

    mem_loader #(
        .IMEM_WORDS (IW),
        .DMEM_WORDS (DW),
        .START_DELAY(DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .tbStart     (tbStart),
        .initInstAddr(initInstAddr),
        .err         (err),
        .load_count  (load_count)
    );

    typedef struct {
        logic        tgt;   // 0 = imem, 1 = dmem
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem_i [IW];
    logic [31:0] mem_d [DW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory side of the write ports: checks against the scoreboard and
    // keeps the memory image the core would later read.
    task automatic check_wr(input logic tgt, input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        check(tgt ? "dmem_we_expected" : "imem_we_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_target", 32'(tgt), 32'(e.tgt));
            check("wr_addr", a, e.addr);
            check("wr_data", d, e.data);
            $display("write tgt=%0d addr=%h data=%h", tgt, a, d);
        end
        if (!tgt) mem_i[a[7:2]] = d;
        else      mem_d[a[7:2]] = d;
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) check_wr(1'b0, imem_addr, imem_wdata);
        if (dmem_we === 1'b1) check_wr(1'b1, dmem_addr, dmem_wdata);
    end

    task automatic send(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                        input logic last, input logic exp_wr);
        wr_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_addr  = a;
        in_data  = d;
        in_last  = last;
        if (exp_wr && in_ready) begin
            e.tgt  = sel[0];
            e.addr = a;
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        $display("reset check: %s", tag);
        check({tag, "_in_ready"},   32'(in_ready), 32'd1);
        check({tag, "_imem_we"},    32'(imem_we), 32'd0);
        check({tag, "_dmem_we"},    32'(dmem_we), 32'd0);
        check({tag, "_imem_addr"},  imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_dmem_addr"},  dmem_addr, 32'd0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_tbStart"},    32'(tbStart), 32'd0);
        check({tag, "_initInst"},   initInstAddr, 32'd0);
        check({tag, "_err"},        32'(err), 32'd0);
        check({tag, "_load_count"}, 32'(load_count), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_reset_vals(tag);
    endtask

    int unsigned exp_mv [3] = '{32'd14, 32'd32, 32'd50};

    initial begin
        logic [31:0] acc;
        logic [31:0] dval;

        // Power-on reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("por");

        // Reset mid-load after 5 beats, then a fresh load
        for (int i = 0; i < 5; i++) send(SEL_IMEM, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        idle();
        check("midload_count", 32'(load_count), 32'd5);
        do_reset("midload");

        // Matrix-vector program load
        for (int i = 0; i < 18; i++)
            send(SEL_IMEM, 32'(i * 4), 32'h0000_0013 | (32'(i) << 20), 1'b0, 1'b1);
        for (int w = 0; w < 15; w++) begin
            dval = (w < 3) ? 32'd0 : (w < 12) ? 32'(w - 2) : 32'(w - 11);
            send(SEL_DMEM, 32'(w * 4), dval, (w == 14), 1'b1);
        end
        idle();
        check("mv_ready_drop", 32'(in_ready), 32'd0);
        check("mv_tbStart_n0", 32'(tbStart), 32'd0);
        for (int k = 1; k <= DLY; k++) begin
            @(negedge clk);
            check("mv_tbStart_settle", 32'(tbStart), 32'd0);
        end
        @(negedge clk);
        check("mv_tbStart_rise", 32'(tbStart), 32'd1);
        check("mv_load_count", 32'(load_count), 32'd33);
        check("mv_initInst", initInstAddr, 32'd0);
        check("mv_imem_w17", mem_i[17], 32'h0110_0013);
        for (int r = 0; r < 3; r++) begin
            acc = 0;
            for (int c = 0; c < 3; c++) acc += mem_d[3 + 3 * r + c] * mem_d[12 + c];
            check("mv_result", acc, exp_mv[r]);
        end
        // Input held in RUN is ignored
        for (int k = 0; k < 4; k++) begin
            send(SEL_DMEM, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
            check("run_imem_we", 32'(imem_we), 32'd0);
            check("run_dmem_we", 32'(dmem_we), 32'd0);
        end
        idle();
        check("run_dmem_we_end", 32'(dmem_we), 32'd0);
        check("run_count", 32'(load_count), 32'd33);
        check("run_tbStart", 32'(tbStart), 32'd1);

        // Entry beat then a single last imem beat
        do_reset("entry");
        send(SEL_ENTRY, 32'h0, 32'h40, 1'b0, 1'b0);
        send(SEL_IMEM, 32'h0, 32'h0000_0013, 1'b1, 1'b1);
        idle();
        check("entry_initInst", initInstAddr, 32'h40);
        repeat (DLY + 1) @(negedge clk);
        check("entry_tbStart", 32'(tbStart), 32'd1);
        check("entry_count", 32'(load_count), 32'd1);

        // Misaligned entry value
        do_reset("entry_bad");
        send(SEL_ENTRY, 32'h0, 32'h42, 1'b0, 1'b0);
        idle();
        check("entry_bad_err", 32'(err), 32'd1);
        check("entry_bad_ready", 32'(in_ready), 32'd0);
        check("entry_bad_initInst", initInstAddr, 32'd0);

        // Misaligned imem address, then input held in ERROR
        do_reset("misalign");
        send(SEL_IMEM, 32'h06, 32'h1234, 1'b0, 1'b0);
        idle();
        check("mis_imem_we", 32'(imem_we), 32'd0);
        check("mis_err", 32'(err), 32'd1);
        check("mis_ready", 32'(in_ready), 32'd0);
        check("mis_tbStart", 32'(tbStart), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send(SEL_DMEM, 32'h8, 32'h5555, 1'b1, 1'b0);
            check("err_dmem_we", 32'(dmem_we), 32'd0);
        end
        idle();
        check("err_dmem_we_end", 32'(dmem_we), 32'd0);
        check("err_count", 32'(load_count), 32'd0);
        check("err_tbStart", 32'(tbStart), 32'd0);

        // Range boundary: word 63 legal, word 64 illegal
        do_reset("range");
        send(SEL_DMEM, 32'hFC, 32'hCAFE_0001, 1'b0, 1'b1);
        send(SEL_DMEM, 32'h100, 32'hBEEF_0002, 1'b0, 1'b0);
        idle();
        check("range_dmem_we", 32'(dmem_we), 32'd0);
        check("range_err", 32'(err), 32'd1);
        check("range_word63", mem_d[63], 32'hCAFE_0001);
        check("range_count", 32'(load_count), 32'd1);

        // Reserved select that is also last: error wins over settle
        do_reset("rsvd");
        send(2'b11, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        check("rsvd_err", 32'(err), 32'd1);
        repeat (DLY + 2) @(negedge clk);
        check("rsvd_tbStart", 32'(tbStart), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
